// File: rtl/fb_pkg.sv
// Shared types for the frame-buffer write arbiter: arbiter states, pixel and FIFO entry layout.
package fb_pkg;

  localparam int unsigned FB_H_RES  = 640;
  localparam int unsigned FB_V_RES  = 480;
  localparam int unsigned FB_ADDR_W = 20;

  // State names the command currently presented to the SRAM controller
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRead  = 2'd1,
    StWrite = 2'd2
  } arb_state_e;

  // {R[4:0], G[5:0], B[4:0]}
  typedef logic [15:0] rgb565_t;

  // Reference FIFO entry layout at the default address width
  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    rgb565_t              data;
  } fb_entry_t;

endpackage

// File: rtl/fb_sync_fifo.sv
// Single-clock circular FIFO with wrap-bit pointers and a registered occupancy count.
// Head entry is read combinationally; push while full is legal only together with pop.
module fb_sync_fifo #(
  parameter int unsigned WIDTH = 36,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr_q;
  logic [PTR_W:0]   rd_ptr_q;
  logic [PTR_W:0]   level_q;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign rdata = mem[rd_ptr_q[PTR_W-1:0]];
  assign level = level_q;

  // Storage array; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q[PTR_W-1:0]] <= wdata;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      level_q <= level_q + 1'b1;
      else if (pop && !push) level_q <= level_q - 1'b1;
    end
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Decimates camera pixels into a write FIFO and shares the single-port SRAM between VGA
// reads (always first) and buffered camera writes. All SRAM command outputs are registered.
// Optional build macro FB_DROP_COUNT_EN adds a saturating lost-pixel counter port drop_count.
module fb_write_arbiter
  import fb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned H_RES      = FB_H_RES,
  parameter int unsigned V_RES      = FB_V_RES,
  parameter int unsigned ADDR_W     = FB_ADDR_W
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  input  logic                          pix_valid,
  input  logic [15:0]                   pix_data,
  input  logic [10:0]                   pix_x,
  input  logic [10:0]                   pix_y,
  input  logic                          rd_req,
  input  logic [ADDR_W-1:0]             rd_addr,
  input  logic                          sram_ready,
  output logic [ADDR_W-1:0]             sram_addr,
  output logic                          sram_read,
  output logic                          sram_write,
  output logic [15:0]                   sram_wdata,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
`ifdef FB_DROP_COUNT_EN
  ,
  output logic [15:0]                   drop_count
`endif
);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    rgb565_t           data;
  } entry_t;

  arb_state_e  state_q;
  entry_t      push_entry;
  entry_t      head_entry;
  logic [31:0] x_ext;
  logic [31:0] y_ext;
  logic        pix_accept;
  logic        advance;
  logic        push;
  logic        pop;
  logic        drop;
  logic        fifo_full;
  logic        fifo_empty;

  // Keep only even rows/columns that land inside the frame
  assign x_ext      = 32'(pix_x);
  assign y_ext      = 32'(pix_y);
  assign pix_accept = pix_valid && !pix_x[0] && !pix_y[0] &&
                      (x_ext < 2 * H_RES) && (y_ext < 2 * V_RES);

  assign push_entry.addr = ADDR_W'(pix_y >> 1) * ADDR_W'(H_RES) + ADDR_W'(pix_x >> 1);
  assign push_entry.data = pix_data;

  // A stalled command must stay on the bus until the controller takes it
  assign advance = (state_q == StIdle) || sram_ready;
  assign pop     = advance && !rd_req && !fifo_empty;
  assign push    = pix_accept && (!fifo_full || pop);
  assign drop    = pix_accept && fifo_full && !pop;

  fb_sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (Clk),
    .rst_n (Reset_n),
    .push  (push),
    .pop   (pop),
    .wdata (push_entry),
    .rdata (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Command register: reads win, queued writes fill the remaining slots
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= StIdle;
      sram_addr  <= '0;
      sram_read  <= 1'b0;
      sram_write <= 1'b0;
      sram_wdata <= '0;
    end else if (advance) begin
      if (rd_req) begin
        state_q    <= StRead;
        sram_addr  <= rd_addr;
        sram_read  <= 1'b1;
        sram_write <= 1'b0;
      end else if (!fifo_empty) begin
        state_q    <= StWrite;
        sram_addr  <= head_entry.addr;
        sram_wdata <= head_entry.data;
        sram_read  <= 1'b0;
        sram_write <= 1'b1;
      end else begin
        state_q    <= StIdle;
        sram_read  <= 1'b0;
        sram_write <= 1'b0;
      end
    end
  end

  // Sticky lost-pixel flag
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

`ifdef FB_DROP_COUNT_EN
  // Saturating count of lost pixels
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      drop_count <= '0;
    end else if (drop && (drop_count != 16'hFFFF)) begin
      drop_count <= drop_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Self-checking bench for fb_write_arbiter: vector table, directed corner sequences and a
// randomized run against a queue-based reference model.
module tb_fb_write_arbiter;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned HR    = 640;
  localparam int unsigned VR    = 480;
  localparam int unsigned AW    = 20;

  logic          Clk = 1'b0;
  logic          Reset_n = 1'b1;
  logic          pix_valid;
  logic [15:0]   pix_data;
  logic [10:0]   pix_x;
  logic [10:0]   pix_y;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          sram_ready;
  logic [AW-1:0] sram_addr;
  logic          sram_read;
  logic          sram_write;
  logic [15:0]   sram_wdata;
  logic [4:0]    fifo_level;
  logic          overflow;
`ifdef FB_DROP_COUNT_EN
  logic [15:0]   drop_count;
`endif

  int checks = 0;
  int errors = 0;

  fb_write_arbiter #(
    .FIFO_DEPTH (DEPTH),
    .H_RES      (HR),
    .V_RES      (VR),
    .ADDR_W     (AW)
  ) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .sram_ready (sram_ready),
    .sram_addr  (sram_addr),
    .sram_read  (sram_read),
    .sram_write (sram_write),
    .sram_wdata (sram_wdata),
    .fifo_level (fifo_level),
    .overflow   (overflow)
`ifdef FB_DROP_COUNT_EN
    ,
    .drop_count (drop_count)
`endif
  );

  always #5 Clk = ~Clk;

  // Reference model: queue of pending {addr, data}, current command, lost-pixel state
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } ent_t;

  ent_t          mq[$];
  int            m_kind;   // 0 idle, 1 read, 2 write
  logic [AW-1:0] m_addr;
  logic [15:0]   m_wdata;
  bit            m_ovf;
  int            m_drops;

  typedef struct {
    bit          v;
    int          x;
    int          y;
    bit          rd;
    int          ra;
    bit          e_rd;
    bit          e_wr;
    int          e_addr;
    int          e_lvl;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input bit v, input int x, input int y, input logic [15:0] d,
                        input bit rd, input int ra, input bit rdy);
    pix_valid  = v;
    pix_x      = 11'(x);
    pix_y      = 11'(y);
    pix_data   = d;
    rd_req     = rd;
    rd_addr    = AW'(ra);
    sram_ready = rdy;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic model_reset();
    mq.delete();
    m_kind  = 0;
    m_addr  = '0;
    m_wdata = '0;
    m_ovf   = 0;
    m_drops = 0;
  endtask

  // Applies the current inputs to the model for one clock edge
  task automatic model_step();
    ent_t e;
    int   xi;
    int   yi;
    bit   acc;
    xi  = int'(pix_x);
    yi  = int'(pix_y);
    acc = pix_valid && (xi % 2 == 0) && (yi % 2 == 0) && (xi < 2 * HR) && (yi < 2 * VR);
    if (m_kind == 0 || sram_ready) begin
      if (rd_req) begin
        m_kind = 1;
        m_addr = rd_addr;
      end else if (mq.size() > 0) begin
        e       = mq.pop_front();
        m_kind  = 2;
        m_addr  = e.addr;
        m_wdata = e.data;
      end else begin
        m_kind = 0;
      end
    end
    if (acc) begin
      if (mq.size() < DEPTH) begin
        e.addr = AW'((yi / 2) * HR + xi / 2);
        e.data = pix_data;
        mq.push_back(e);
      end else begin
        m_ovf = 1;
        if (m_drops < 65535) m_drops++;
      end
    end
  endtask

  task automatic cmp_model(input int cyc);
    string tag;
    tag = $sformatf("rand[%0d]", cyc);
    chk({tag, ".read"}, 32'(sram_read), 32'(m_kind == 1));
    chk({tag, ".write"}, 32'(sram_write), 32'(m_kind == 2));
    chk({tag, ".excl"}, 32'(sram_read & sram_write), 32'd0);
    chk({tag, ".level"}, 32'(fifo_level), 32'(mq.size()));
    chk({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
    if (m_kind != 0) chk({tag, ".addr"}, 32'(sram_addr), 32'(m_addr));
    if (m_kind == 2) chk({tag, ".wdata"}, 32'(sram_wdata), 32'(m_wdata));
`ifdef FB_DROP_COUNT_EN
    chk({tag, ".drops"}, 32'(drop_count), 32'(m_drops));
`endif
  endtask

  // Asserts reset mid-cycle, checks the asynchronous clear, releases after the next edge
  task automatic do_reset(input string tag);
    Reset_n = 1'b0;
    set_in(0, 0, 0, 16'h0, 0, 0, 1);
    #2;
    chk({tag, ".rst_read"}, 32'(sram_read), 32'd0);
    chk({tag, ".rst_write"}, 32'(sram_write), 32'd0);
    chk({tag, ".rst_addr"}, 32'(sram_addr), 32'd0);
    chk({tag, ".rst_wdata"}, 32'(sram_wdata), 32'd0);
    chk({tag, ".rst_level"}, 32'(fifo_level), 32'd0);
    chk({tag, ".rst_ovf"}, 32'(overflow), 32'd0);
`ifdef FB_DROP_COUNT_EN
    chk({tag, ".rst_drops"}, 32'(drop_count), 32'd0);
`endif
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    // {v, x, y, rd, rd_addr, exp_read, exp_write, exp_addr, exp_level}, sram_ready held 1
    tbl[0] = '{1, 0,    0,   0, 0,       0, 0, 0,       1};
    tbl[1] = '{1, 1,    0,   0, 0,       0, 1, 0,       0};
    tbl[2] = '{1, 2,    2,   0, 0,       0, 0, 0,       1};
    tbl[3] = '{1, 4,    6,   0, 0,       0, 1, 641,     1};
    tbl[4] = '{0, 0,    0,   0, 0,       0, 1, 1922,    0};
    tbl[5] = '{0, 0,    0,   0, 0,       0, 0, 0,       0};
    tbl[6] = '{0, 0,    0,   1, 'h12345, 1, 0, 'h12345, 0};
    tbl[7] = '{1, 3,    3,   0, 0,       0, 0, 0,       0};
    tbl[8] = '{1, 1280, 0,   0, 0,       0, 0, 0,       0};
    tbl[9] = '{1, 0,    960, 0, 0,       0, 0, 0,       0};

    set_in(0, 0, 0, 16'h0, 0, 0, 1);
    #1;
    do_reset("init");

    // Decimation and basic command flow
    for (int i = 0; i < 10; i++) begin
      string tag;
      tag = $sformatf("vec[%0d]", i);
      set_in(tbl[i].v, tbl[i].x, tbl[i].y, 16'hF800, tbl[i].rd, tbl[i].ra, 1);
      tick();
      chk({tag, ".read"}, 32'(sram_read), 32'(tbl[i].e_rd));
      chk({tag, ".write"}, 32'(sram_write), 32'(tbl[i].e_wr));
      chk({tag, ".level"}, 32'(fifo_level), 32'(tbl[i].e_lvl));
      chk({tag, ".ovf"}, 32'(overflow), 32'd0);
      if (tbl[i].e_rd || tbl[i].e_wr) chk({tag, ".addr"}, 32'(sram_addr), 32'(tbl[i].e_addr));
      if (tbl[i].e_wr) chk({tag, ".wdata"}, 32'(sram_wdata), 32'hF800);
    end

    // Read priority: three queued pixels wait behind five reads, then drain back-to-back
    do_reset("prio");
    for (int i = 0; i < 3; i++) begin
      set_in(1, 2 * i, 0, 16'(i + 1), 1, 100 + i, 1);
      tick();
      chk("prio.fill_read", 32'(sram_read), 32'd1);
      chk("prio.fill_addr", 32'(sram_addr), 32'(100 + i));
      chk("prio.fill_level", 32'(fifo_level), 32'(i + 1));
    end
    for (int i = 0; i < 5; i++) begin
      set_in(0, 0, 0, 16'h0, 1, 200 + i, 1);
      tick();
      chk("prio.read", 32'(sram_read), 32'd1);
      chk("prio.no_write", 32'(sram_write), 32'd0);
      chk("prio.read_addr", 32'(sram_addr), 32'(200 + i));
      chk("prio.level_held", 32'(fifo_level), 32'd3);
    end
    for (int i = 0; i < 3; i++) begin
      set_in(0, 0, 0, 16'h0, 0, 0, 1);
      tick();
      chk("prio.write", 32'(sram_write), 32'd1);
      chk("prio.write_addr", 32'(sram_addr), 32'(i));
      chk("prio.write_data", 32'(sram_wdata), 32'(i + 1));
      chk("prio.drain_level", 32'(fifo_level), 32'(2 - i));
    end
    tick();
    chk("prio.idle", 32'(sram_write | sram_read), 32'd0);

    // Backpressure: a stalled write holds its outputs and does not pop
    do_reset("bp");
    set_in(1, 6, 0, 16'hABCD, 0, 0, 1);
    tick();
    chk("bp.no_fallthrough", 32'(sram_write), 32'd0);
    set_in(0, 0, 0, 16'h0, 0, 0, 1);
    tick();
    chk("bp.write", 32'(sram_write), 32'd1);
    chk("bp.addr", 32'(sram_addr), 32'd3);
    for (int i = 0; i < 4; i++) begin
      if (i == 0) set_in(1, 8, 0, 16'h1234, 0, 0, 0);
      else        set_in(0, 0, 0, 16'h0, 0, 0, 0);
      tick();
      chk("bp.hold_write", 32'(sram_write), 32'd1);
      chk("bp.hold_addr", 32'(sram_addr), 32'd3);
      chk("bp.hold_wdata", 32'(sram_wdata), 32'hABCD);
      chk("bp.no_pop", 32'(fifo_level), 32'd1);
    end
    set_in(0, 0, 0, 16'h0, 0, 0, 1);
    tick();
    chk("bp.next_write", 32'(sram_write), 32'd1);
    chk("bp.next_addr", 32'(sram_addr), 32'd4);
    chk("bp.next_wdata", 32'(sram_wdata), 32'h1234);
    chk("bp.next_level", 32'(fifo_level), 32'd0);

    // Full FIFO with a simultaneous pop accepts the new pixel
    do_reset("fullpop");
    for (int i = 0; i < 16; i++) begin
      set_in(1, 2 * i, 0, 16'(i + 1), 1, 0, 1);
      tick();
    end
    chk("fullpop.full_level", 32'(fifo_level), 32'd16);
    set_in(1, 100, 2, 16'h7777, 0, 0, 1);
    tick();
    chk("fullpop.write", 32'(sram_write), 32'd1);
    chk("fullpop.addr", 32'(sram_addr), 32'd0);
    chk("fullpop.wdata", 32'(sram_wdata), 32'd1);
    chk("fullpop.level", 32'(fifo_level), 32'd16);
    chk("fullpop.ovf", 32'(overflow), 32'd0);
    for (int j = 1; j < 17; j++) begin
      set_in(0, 0, 0, 16'h0, 0, 0, 1);
      tick();
      chk("fullpop.drain_addr", 32'(sram_addr), (j < 16) ? 32'(j) : 32'd690);
      chk("fullpop.drain_wdata", 32'(sram_wdata), (j < 16) ? 32'(j + 1) : 32'h7777);
    end

    // Overflow: continuous reads starve writes, the 17th pixel is lost
    do_reset("ovf");
    for (int i = 0; i < 17; i++) begin
      set_in(1, 2 * i, 0, 16'(i), 1, 5, 1);
      tick();
      if (i == 15) chk("ovf.not_yet", 32'(overflow), 32'd0);
    end
    chk("ovf.level", 32'(fifo_level), 32'd16);
    chk("ovf.flag", 32'(overflow), 32'd1);
    chk("ovf.starved_read", 32'(sram_read), 32'd1);
`ifdef FB_DROP_COUNT_EN
    chk("ovf.drop_count", 32'(drop_count), 32'd1);
`endif
    set_in(0, 0, 0, 16'h0, 0, 0, 1);
    tick();
    chk("ovf.sticky", 32'(overflow), 32'd1);

    // Reset mid-write clears commands and FIFO contents
    do_reset("midrst");
    set_in(1, 10, 4, 16'h5555, 0, 0, 1);
    tick();
    set_in(1, 12, 4, 16'h6666, 0, 0, 0);
    tick();
    chk("midrst.pre_write", 32'(sram_write), 32'd1);
    chk("midrst.pre_addr", 32'(sram_addr), 32'd1285);
    chk("midrst.pre_level", 32'(fifo_level), 32'd1);
    do_reset("midrst");
    set_in(0, 0, 0, 16'h0, 0, 0, 1);
    tick();
    chk("midrst.post_level", 32'(fifo_level), 32'd0);
    chk("midrst.post_write", 32'(sram_write), 32'd0);

    // Randomized traffic against the reference model
    do_reset("rand");
    for (int c = 0; c < 3000; c++) begin
      int rdlvl;
      rdlvl = ((c / 300) % 5) * 2 + 1;
      set_in($urandom_range(0, 9) < 8,
             int'($urandom_range(0, 650)) * 2 + int'($urandom_range(0, 4) == 0),
             int'($urandom_range(0, 485)) * 2 + int'($urandom_range(0, 4) == 0),
             16'($urandom), $urandom_range(0, 9) < rdlvl, int'($urandom & 32'hFFFFF),
             $urandom_range(0, 3) != 0);
      model_step();
      tick();
      cmp_model(c);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
